// File: rtl/vga_text_pkg.sv
// Shared timing constants, glyph geometry and stage-1 sideband type for the VGA text scan path.
package vga_text_pkg;

    localparam int H_ACTIVE_DFLT = 640;
    localparam int H_FP_DFLT     = 16;
    localparam int H_SYNC_DFLT   = 96;
    localparam int H_BP_DFLT     = 48;
    localparam int V_ACTIVE_DFLT = 480;
    localparam int V_FP_DFLT     = 10;
    localparam int V_SYNC_DFLT   = 2;
    localparam int V_BP_DFLT     = 33;

    localparam int H_TOTAL      = H_ACTIVE_DFLT + H_FP_DFLT + H_SYNC_DFLT + H_BP_DFLT;
    localparam int V_TOTAL      = V_ACTIVE_DFLT + V_FP_DFLT + V_SYNC_DFLT + V_BP_DFLT;
    localparam int H_SYNC_START = H_ACTIVE_DFLT + H_FP_DFLT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_DFLT;
    localparam int V_SYNC_START = V_ACTIVE_DFLT + V_FP_DFLT;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_DFLT;

    localparam int GLYPH_W     = 8;
    localparam int GLYPH_H     = 16;
    localparam int TEXT_COLS   = 80;
    localparam int TEXT_ROWS   = 30;
    localparam int TEXT_ADDR_W = 12;
    localparam int CNT_W       = 10;

    typedef struct packed {
        logic [2:0] col;
        logic [3:0] row;
        logic       hs;
        logic       vs;
        logic       blank;
        logic       first;
    } scan_side_t;

    localparam scan_side_t SIDE_RESET = '{col: 3'd0, row: 4'd0, hs: 1'b1, vs: 1'b1,
                                          blank: 1'b1, first: 1'b0};

    // row*80 + col as shift-add; row < 30 inside the active area so 12 bits never overflow
    function automatic logic [TEXT_ADDR_W-1:0] cell_addr(input logic [5:0] row,
                                                         input logic [6:0] col);
        logic [TEXT_ADDR_W-1:0] rw;
        rw = {6'd0, row};
        return (rw << 6) + (rw << 4) + {5'd0, col};
    endfunction

endpackage

// File: rtl/vga_timing_counter.sv
// Pixel/line counters with active-area and sync decode; advances only on pix_en.
module vga_timing_counter
    import vga_text_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DFLT,
    parameter int H_FP     = H_FP_DFLT,
    parameter int H_SYNC   = H_SYNC_DFLT,
    parameter int H_BP     = H_BP_DFLT,
    parameter int V_ACTIVE = V_ACTIVE_DFLT,
    parameter int V_FP     = V_FP_DFLT,
    parameter int V_SYNC   = V_SYNC_DFLT,
    parameter int V_BP     = V_BP_DFLT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_en,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             active,
    output logic             hs,
    output logic             vs,
    output logic             first
);

    localparam int HT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HSS = H_ACTIVE + H_FP;
    localparam int HSE = HSS + H_SYNC;
    localparam int VSS = V_ACTIVE + V_FP;
    localparam int VSE = VSS + V_SYNC;

    logic [CNT_W-1:0] h_cnt_d, h_cnt_q;
    logic [CNT_W-1:0] v_cnt_d, v_cnt_q;

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (pix_en) begin
            if (h_cnt_q == CNT_W'(HT - 1)) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == CNT_W'(VT - 1)) ? '0 : v_cnt_q + 1'b1;
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign h_cnt  = h_cnt_q;
    assign v_cnt  = v_cnt_q;
    assign active = (h_cnt_q < CNT_W'(H_ACTIVE)) && (v_cnt_q < CNT_W'(V_ACTIVE));
    assign hs     = ~((h_cnt_q >= CNT_W'(HSS)) && (h_cnt_q < CNT_W'(HSE)));
    assign vs     = ~((v_cnt_q >= CNT_W'(VSS)) && (v_cnt_q < CNT_W'(VSE)));
    assign first  = (h_cnt_q == '0) && (v_cnt_q == '0);

endmodule

// File: rtl/text_scan_generator.sv
// VGA text scan front end: timing, text-buffer addressing and a two-stage alignment pipeline
// so character code, glyph position, syncs and blank all describe the same pixel.
module text_scan_generator
    import vga_text_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DFLT,
    parameter int H_FP     = H_FP_DFLT,
    parameter int H_SYNC   = H_SYNC_DFLT,
    parameter int H_BP     = H_BP_DFLT,
    parameter int V_ACTIVE = V_ACTIVE_DFLT,
    parameter int V_FP     = V_FP_DFLT,
    parameter int V_SYNC   = V_SYNC_DFLT,
    parameter int V_BP     = V_BP_DFLT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pix_en,
    output logic [TEXT_ADDR_W-1:0] ram_addr,
    input  logic [7:0]             ram_data,
    output logic [7:0]             caracter,
    output logic [2:0]             columna,
    output logic [3:0]             fila,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   VGA_blank,
    output logic                   frame_start
);

    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic             active, hs, vs, first;

    vga_timing_counter #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk   (clk),
        .rst_n (rst_n),
        .pix_en(pix_en),
        .h_cnt (h_cnt),
        .v_cnt (v_cnt),
        .active(active),
        .hs    (hs),
        .vs    (vs),
        .first (first)
    );

    logic [TEXT_ADDR_W-1:0] addr_p1_d, addr_p1_q;
    scan_side_t             side_p1_d, side_p1_q;
    scan_side_t             side_p2_d, side_p2_q;
    logic                   en_last_d, en_last_q;
    logic [7:0]             char_hold_d, char_hold_q;
    logic [7:0]             char_p2;

    // Stage 0 -> 1: address arithmetic and sideband capture
    always_comb begin
        addr_p1_d = addr_p1_q;
        side_p1_d = side_p1_q;
        side_p2_d = side_p2_q;
        if (pix_en) begin
            addr_p1_d = active ? cell_addr(v_cnt[9:4], h_cnt[9:3]) : '0;
            side_p1_d = '{col: h_cnt[2:0], row: v_cnt[3:0], hs: hs, vs: vs,
                          blank: ~active, first: first};
            side_p2_d = side_p1_q;
        end
    end

    // Stage 1 -> 2: the RAM output register is the char stage. Right after an enabled edge
    // it holds the word for the pixel now in side_p2; after a stalled edge it has already
    // moved on to the next address, so the last presented code is held instead.
    assign char_p2 = en_last_q ? ram_data : char_hold_q;

    always_comb begin
        en_last_d   = pix_en;
        char_hold_d = char_p2;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_p1_q   <= '0;
            side_p1_q   <= SIDE_RESET;
            side_p2_q   <= SIDE_RESET;
            en_last_q   <= 1'b0;
            char_hold_q <= '0;
        end else begin
            addr_p1_q   <= addr_p1_d;
            side_p1_q   <= side_p1_d;
            side_p2_q   <= side_p2_d;
            en_last_q   <= en_last_d;
            char_hold_q <= char_hold_d;
        end
    end

    assign ram_addr    = addr_p1_q;
    assign caracter    = char_p2;
    assign columna     = side_p2_q.col;
    assign fila        = side_p2_q.row;
    assign hsync       = side_p2_q.hs;
    assign vsync       = side_p2_q.vs;
    assign VGA_blank   = side_p2_q.blank;
    assign frame_start = side_p2_q.first;

endmodule
